// File: rtl/fifo_arb_pkg.sv
// Shared constants and state encoding for the async FIFO write-port arbiter.
// Defaults match the 32-entry FIFO (6-bit binary/Gray pointers) it feeds.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    localparam int FIFO_DEPTH = 32;
    localparam int FIFO_PTR_W = 6;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
// Ports: req (requests), last (previous winner) -> pick (index), any (found).
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] pick,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int unsigned idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        // Offsets 1..NUM_REQ visit every index once, ending at 'last' itself.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with packet lock and burst cap for the FIFO.
// Ports: req_valid/req_data/req_last/req_ready per producer; fifo_full in,
// fifo_wr_en/fifo_wr_data out; grant_id and grant_active for visibility.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [IDX_W-1:0]  pick;
    logic              any;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req  (req_valid),
        .last (last_grant_q),
        .pick (pick),
        .any  (any)
    );

    // Granted requester's lane.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDX_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        xfer         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d      = GRANT;
                    grant_id_d   = pick;
                    last_grant_d = pick;
                    burst_cnt_d  = '0;
                end
            end
            GRANT: begin
                // Outputs are held off while reset is asserted so a write
                // can never land in the cycle that is being reset.
                if (!reset) begin
                    req_ready[grant_id_q] = ~fifo_full;
                    xfer                  = g_valid & ~fifo_full;
                    fifo_wr_en            = xfer;
                    fifo_wr_data          = g_data;
                end
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Full alone never releases; a withdrawn requester does.
                if ((xfer && (g_last || burst_cnt_q == BURST_LAST))
                    || !g_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= LAST_RST;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign grant_id     = grant_id_q;
    assign grant_active = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: packet producers plus write monitor.
// Expected (id, data) writes are queued at stimulus time, popped on writes.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  grant_id;
    logic        grant_active;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [9:0] exp_q[$];
    logic [3:0] acc_n;

    bit en[4];
    bit has_last[4];
    int len[4];
    int pos[4];

    function automatic logic [7:0] dat(input int i, input int p);
        return 8'((i << 5) | p);
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, req);
        end
    endtask

    // Monitor: sample handshakes and score every FIFO write.
    always @(negedge clk) begin
        acc_n = req_ready & req_valid;
        if (fifo_wr_en) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected got id=%0d data=%0h expected none",
                         grant_id, fifo_wr_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({grant_id, fifo_wr_data} !== e) begin
                    fails++;
                    $display("FAIL wr_word got id=%0d data=%0h expected id=%0d data=%0h",
                             grant_id, fifo_wr_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = en[i] && (pos[i] < len[i]);
            req_data[i*8 +: 8]  = dat(i, pos[i]);
            req_last[i]         = has_last[i] && (pos[i] == len[i] - 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (acc_n[i]) pos[i]++;
        end
        #1;
        drive();
    endtask

    task automatic cfg(input int i, input int l, input bit lst);
        en[i]       = 1'b1;
        pos[i]      = 0;
        len[i]      = l;
        has_last[i] = lst;
    endtask

    task automatic exp_w(input int i, input int p0, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({2'(i), dat(i, p0 + k)});
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en[i]       = 1'b0;
            has_last[i] = 1'b0;
            len[i]      = 0;
            pos[i]      = 0;
        end
        drive();
        tick();
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || grant_active) && n < 300) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || grant_active) begin
            fails++;
            $display("FAIL %s_drain got pending=%0d active=%0b expected 0 0",
                     name, exp_q.size(), grant_active);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        acc_n     = '0;

        // 1: reset state, single 3-word packet from requester 0
        do_reset();
        @(negedge clk);
        chk("rst_active", 32'(grant_active), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_wr_data", 32'(fifo_wr_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        reset = 1'b0;
        cfg(0, 3, 1'b1);
        drive();
        exp_w(0, 0, 3);
        #1;
        chk("t1_idle_no_write", 32'(fifo_wr_en), 0);
        tick();
        @(negedge clk);
        chk("t1_active", 32'(grant_active), 1);
        chk("t1_gid", 32'(grant_id), 0);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t1_released", 32'(grant_active), 0);
        chk("t1_idle_data", 32'(fifo_wr_data), 0);
        drain("t1");

        // 2: all four long packets, burst cap rotation
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cfg(i, 12, 1'b0);
        drive();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) exp_w(i, r * 4, 4);
        end
        tick();
        @(negedge clk);
        chk("t2_first_gid", 32'(grant_id), 0);
        tick();
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t2_dead_cycle", 32'(grant_active), 0);
        tick();
        @(negedge clk);
        chk("t2_second_gid", 32'(grant_id), 1);
        drain("t2");

        // 3: fifo_full stall mid-burst on requester 2
        do_reset();
        reset = 1'b0;
        cfg(2, 6, 1'b0);
        drive();
        exp_w(2, 0, 6);
        tick();
        @(negedge clk);
        chk("t3_gid", 32'(grant_id), 2);
        tick();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_full_ready", 32'(req_ready), 0);
            chk("t3_full_wr_en", 32'(fifo_wr_en), 0);
            chk("t3_full_gid", 32'({grant_active, grant_id}), 32'h6);
            tick();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("t3_resume", 32'(fifo_wr_en), 1);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t3_cap_release", 32'(grant_active), 0);
        drain("t3");

        // 4: requester 1 withdraws, requester 3 takes over
        do_reset();
        reset = 1'b0;
        cfg(1, 2, 1'b0);
        cfg(3, 3, 1'b1);
        drive();
        exp_w(1, 0, 2);
        exp_w(3, 0, 3);
        tick();
        @(negedge clk);
        chk("t4_gid1", 32'(grant_id), 1);
        tick();
        tick();
        @(negedge clk);
        chk("t4_withdrawn", 32'({grant_active, fifo_wr_en}), 32'h2);
        tick();
        @(negedge clk);
        chk("t4_idle", 32'(grant_active), 0);
        tick();
        @(negedge clk);
        chk("t4_gid3", 32'({grant_active, grant_id}), 32'h7);
        drain("t4");

        // 5: reset pulse during an active transfer
        do_reset();
        reset = 1'b0;
        cfg(0, 8, 1'b0);
        cfg(2, 8, 1'b0);
        drive();
        exp_w(0, 0, 5);
        exp_w(2, 0, 4);
        exp_w(0, 5, 3);
        exp_w(2, 4, 4);
        tick();
        @(negedge clk);
        chk("t5_active", 32'(grant_active), 1);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_wr_en", 32'(fifo_wr_en), 0);
        chk("t5_rst_ready", 32'(req_ready), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_after_rst", 32'({grant_active, fifo_wr_en, grant_id}), 0);
        tick();
        @(negedge clk);
        chk("t5_regrant", 32'({grant_active, grant_id}), 32'h4);
        drain("t5");

        // 6: wrap search from last_grant=3 with 4'b1001
        do_reset();
        reset = 1'b0;
        cfg(3, 1, 1'b1);
        drive();
        exp_w(3, 0, 1);
        tick();
        @(negedge clk);
        chk("t6_gid3_first", 32'(grant_id), 3);
        tick();
        cfg(0, 1, 1'b1);
        len[3] = 2;
        drive();
        exp_w(0, 0, 1);
        exp_w(3, 1, 1);
        @(negedge clk);
        chk("t6_idle", 32'(grant_active), 0);
        tick();
        @(negedge clk);
        chk("t6_wrap_gid0", 32'({grant_active, grant_id}), 32'h4);
        tick();
        tick();
        @(negedge clk);
        chk("t6_next_gid3", 32'({grant_active, grant_id}), 32'h7);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of the 32-entry async FIFO (6-bit binary/Gray pointer scheme) between NUM_REQ producers in the write clock domain.
- Round-robin grant with packet lock and a burst cap.
- Drives fifo_wr_en/fifo_wr_data from the granted requester and back-pressures all requesters on fifo_full.
- Sits directly in front of the FIFO write side; fifo_full comes from the write-side pointer compare.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, FIFO word width.
- MAX_BURST, 4, max words per grant before forced rotation (1..16).

Ports:
- clk  input  1  write-domain clock.
- reset  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_W  per-requester data; requester i at [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  marks final word of requester's packet.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  input  1  FIFO full flag, write domain.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wr_data  output  DATA_W  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  currently granted requester index.
- grant_active  output  1  high while in GRANT state.

Behaviour:
Single clock domain. Reset is synchronous, active-high, sampled on the rising edge of clk. Registered state:
- state
- grant_id
- last_grant
- burst_cnt, width $clog2(MAX_BURST+1)

Reset values:
- state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), burst_cnt=0.
- Outputs: grant_active=0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0.

State machine:
- IDLE: if any req_valid, pick the first valid index searching from last_grant+1 upward with wrap. Register grant_id=pick and last_grant=pick, clear burst_cnt, go to GRANT. Otherwise stay in IDLE. Arbitration latency is 1 cycle; no transfer happens in IDLE.
- GRANT, let g=grant_id:
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - xfer = req_valid[g] & req_ready[g].
  - fifo_wr_en = xfer; fifo_wr_data = req_data[g]. Both are combinational from registered grant plus inputs; fifo_wr_data is 0 when not in GRANT.
  - On xfer, burst_cnt increments.
  - Release to IDLE at the next edge when any of the following holds:
    - xfer & req_last[g];
    - xfer & burst_cnt==MAX_BURST-1;
    - req_valid[g]==0 (requester withdrew).
  - Otherwise stay in GRANT.

Boundary conditions:
- fifo_full high in GRANT: ready low, no write, burst_cnt holds, grant holds (no release on full alone).
- fifo_full and req_valid[g] low in the same cycle: the release rule applies.
- Burst cap hit mid-packet: grant rotates. The requester re-arbitrates and resumes its packet on a later grant; req_last is not required within MAX_BURST words.
- Every release costs one IDLE cycle. Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Only one requester valid: it is re-granted after each IDLE cycle.
- Reset asserted mid-GRANT: next edge returns to IDLE with reset values; no fifo_wr_en in the reset cycle or the following cycle.
- req_valid for non-granted requesters is ignored in GRANT.
- Index wrap: last_grant=NUM_REQ-1 searches from 0.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding (IDLE=1'b0, GRANT=1'b1);
  - default NUM_REQ/DATA_W/MAX_BURST constants;
  - FIFO depth constant (32) and pointer width (6) shared with the FIFO.
- One sub-module rr_pick: combinational round-robin picker with inputs req[NUM_REQ] and last[$clog2(NUM_REQ)], outputs pick and any. Instantiated once in IDLE arbitration.

Test Plan:
1. Reset, then req_valid=4'b0001 with 3 words, last on the 3rd, fifo_full=0.
   -> grant_active at cycle 1; fifo_wr_en for 3 cycles with data in order; IDLE after the last word.
2. req_valid=4'b1111, all with long packets, MAX_BURST=4.
   -> grants in order 0,1,2,3,0; exactly 4 writes per grant; 1 dead cycle between grants.
3. Granted requester 2 mid-burst, fifo_full=1 for 5 cycles.
   -> req_ready=0 and fifo_wr_en=0 for 5 cycles; grant_id stays 2; burst_cnt unchanged; writing resumes the cycle fifo_full drops.
4. Granted requester 1 drops req_valid after 2 words while 3 is valid.
   -> 1 cycle later IDLE; next grant_id=3.
5. reset pulsed high for 1 cycle while in GRANT with xfer active.
   -> fifo_wr_en=0 and req_ready=0 from the reset edge; grant_active=0; next arbitration picks lowest valid index starting from 0.
6. NUM_REQ=4, last_grant=3, req_valid=4'b1001.
   -> grant_id=0 (wrap search), and next grant is 3.
